// File: rtl/i2c_bus_monitor_pkg.sv
// Shared definitions for the passive I2C bus monitor: event codes, field layout
// and the event-word packing helper.
package i2c_bus_monitor_pkg;

    localparam int EV_SZ   = 11;
    localparam int EV_DATA = 0;   // LSB of the 8-bit data field
    localparam int EV_TYPE = 8;   // LSB of the 3-bit type field

    typedef enum logic [2:0] {
        EV_START     = 3'd0,
        EV_RSTART    = 3'd1,
        EV_STOP      = 3'd2,
        EV_BYTE_ACK  = 3'd3,
        EV_BYTE_NACK = 3'd4,
        EV_ERR       = 3'd5
    } ev_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } mon_state_e;

    function automatic logic [EV_SZ-1:0] mk_event(input ev_type_e typ, input logic [7:0] data);
        return {typ, data};
    endfunction

endpackage

// File: rtl/i2c_mon_fifo.sv
// Synchronous event FIFO with full/empty flags and simultaneous push/pop.
// A push while full only lands if a pop frees a slot in the same cycle.
module i2c_mon_fifo
    import i2c_bus_monitor_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = EV_SZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; head is masked while
    // empty, so stale contents are never visible and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C sniffer: synchronizes and glitch-filters SCL/SDA, decodes
// START/RSTART/STOP/byte/error events and queues them for a host to pop.
module i2c_bus_monitor
    import i2c_bus_monitor_pkg::*;
#(
    parameter int FILT  = 3,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    output logic [EV_SZ-1:0] evt_dat,
    output logic             evt_vld,
    input  logic             evt_rd,
    output logic             ovr,
    input  logic             clr_ovr,
    output logic             busy
);

    localparam int CW = $clog2(FILT + 1);

    // Bit 1 carries SCL, bit 0 carries SDA through the input path.
    logic [1:0]    sync1, sync2, pin_f, pin_q;
    logic [CW-1:0] flt_cnt [2];

    // NOTE: every clocked block uses non-blocking assignments so all state
    // updates see pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            pin_f <= '1;
            pin_q <= '1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync1 <= {scl, sda};
            sync2 <= sync1;
            pin_q <= pin_f;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == pin_f[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CW'(FILT - 1)) begin
                    pin_f[i]   <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_q, sda_q;
    logic start_c, stop_c, scl_rise, scl_fall;

    assign {scl_f, sda_f} = pin_f;
    assign {scl_q, sda_q} = pin_q;
    assign start_c  = scl_q && scl_f &&  sda_q && !sda_f;
    assign stop_c   = scl_q && scl_f && !sda_q &&  sda_f;
    assign scl_rise = !scl_q &&  scl_f;
    assign scl_fall =  scl_q && !scl_f;

    mon_state_e       state, state_n;
    logic [3:0]       bitcnt, bitcnt_n, eff_cnt;
    logic [7:0]       shreg, shreg_n;
    logic             pend, pend_n;
    logic             push;
    logic [EV_SZ-1:0] push_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            pend   <= 1'b0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            pend   <= pend_n;
        end
    end

    // A rise still high when a START/STOP appears is that condition's own
    // clock, not a data bit, so it is discounted from the error bit count.
    assign eff_cnt = bitcnt - {3'b000, pend};

    // NOTE: all outputs of this block get a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        pend_n   = pend;
        push     = 1'b0;
        push_dat = '0;
        case (state)
            ST_IDLE: begin
                if (start_c) begin
                    push     = 1'b1;
                    push_dat = mk_event(EV_START, 8'h00);
                    state_n  = ST_ACTIVE;
                    bitcnt_n = '0;
                    pend_n   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (start_c || stop_c) begin
                    push     = 1'b1;
                    bitcnt_n = '0;
                    pend_n   = 1'b0;
                    if (eff_cnt != '0)
                        push_dat = mk_event(EV_ERR, {eff_cnt, 3'b000, stop_c});
                    else
                        push_dat = mk_event(stop_c ? EV_STOP : EV_RSTART, 8'h00);
                    if (stop_c) state_n = ST_IDLE;
                end else if (scl_rise) begin
                    if (bitcnt == 4'd8) begin
                        push     = 1'b1;
                        push_dat = mk_event(sda_f ? EV_BYTE_NACK : EV_BYTE_ACK, shreg);
                        bitcnt_n = '0;
                    end else begin
                        shreg_n  = {shreg[6:0], sda_f};
                        bitcnt_n = bitcnt + 4'd1;
                        pend_n   = 1'b1;
                    end
                end else if (scl_fall) begin
                    pend_n = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    logic fifo_empty, fifo_full;

    i2c_mon_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_SZ)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (evt_rd),
        .head     (evt_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign evt_vld = !fifo_empty;
    assign busy    = (state == ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst)
            ovr <= 1'b0;
        else if (push && fifo_full && !evt_rd)
            ovr <= 1'b1;
        else if (clr_ovr)
            ovr <= 1'b0;
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bit-bangs raw SCL/SDA and compares the
// popped event words against hand-computed encodings {type[2:0], data[7:0]}.
module tb_i2c_bus_monitor;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst, scl, sda, evt_rd, clr_ovr;
    logic [10:0] evt_dat;
    logic        evt_vld, ovr, busy;
    int          errors = 0;
    int          checks = 0;

    i2c_bus_monitor #(.FILT(3), .DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda),
        .evt_dat (evt_dat),
        .evt_vld (evt_vld),
        .evt_rd  (evt_rd),
        .ovr     (ovr),
        .clr_ovr (clr_ovr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic hold();
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic bus_start();
        scl = 1'b1; sda = 1'b1; hold();
        sda = 1'b0; hold();
    endtask

    task automatic bus_bit(input logic b);
        scl = 1'b0; hold();
        sda = b;    hold();
        scl = 1'b1; hold();
    endtask

    task automatic bus_byte(input logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) bus_bit(d[i]);
        bus_bit(nack);
    endtask

    task automatic bus_rstart();
        scl = 1'b0; hold();
        sda = 1'b1; hold();
        scl = 1'b1; hold();
        sda = 1'b0; hold();
    endtask

    task automatic bus_stop();
        scl = 1'b0; hold();
        sda = 1'b0; hold();
        scl = 1'b1; hold();
        sda = 1'b1; hold();
    endtask

    // Waits (bounded) for an event and pops it; an impossible word 0x7ff on timeout.
    task automatic pop(output logic [10:0] d);
        logic found;
        found = 1'b0;
        d = 11'h7ff;
        for (int i = 0; i < 200 && !found; i++) begin
            if (evt_vld) begin
                found = 1'b1;
                d = evt_dat;
                evt_rd = 1'b1;
                @(negedge clk);
                evt_rd = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; sda = 1'b1; evt_rd = 1'b0; clr_ovr = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (evt_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", evt_vld); end
        checks++; if (evt_dat !== 11'h000) begin errors++; $display("FAIL reset_dat: got %h expected 000", evt_dat); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        evt_rd = 1'b1;
        @(negedge clk);
        evt_rd = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (evt_vld !== 1'b0) begin errors++; $display("FAIL rd_empty_vld: got %b expected 0", evt_vld); end
    endtask

    task automatic test_single_write();
        logic [10:0] d;
        @(negedge clk) sda = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (evt_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL start_early: got vld=%b busy=%b expected 0 0", evt_vld, busy); end
        @(negedge clk);
        checks++; if (evt_vld !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_latency: got vld=%b busy=%b expected 1 1", evt_vld, busy); end
        checks++; if (evt_dat !== 11'h000) begin errors++; $display("FAIL start_head: got %h expected 000", evt_dat); end
        hold();
        bus_byte(8'h74, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b expected 1", busy); end
        bus_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %b expected 0", busy); end
        pop(d); checks++; if (d !== 11'h000) begin errors++; $display("FAIL wr_ev0: got %h expected 000", d); end
        pop(d); checks++; if (d !== 11'h374) begin errors++; $display("FAIL wr_ev1: got %h expected 374", d); end
        pop(d); checks++; if (d !== 11'h200) begin errors++; $display("FAIL wr_ev2: got %h expected 200", d); end
        @(negedge clk);
        checks++; if (evt_vld !== 1'b0) begin errors++; $display("FAIL wr_drained: got %b expected 0", evt_vld); end
    endtask

    task automatic test_nack();
        logic [10:0] d;
        bus_start();
        bus_byte(8'h77, 1'b1);
        bus_stop();
        pop(d); checks++; if (d !== 11'h000) begin errors++; $display("FAIL nack_ev0: got %h expected 000", d); end
        pop(d); checks++; if (d !== 11'h477) begin errors++; $display("FAIL nack_ev1: got %h expected 477", d); end
        pop(d); checks++; if (d !== 11'h200) begin errors++; $display("FAIL nack_ev2: got %h expected 200", d); end
    endtask

    task automatic test_rstart_read();
        logic [10:0] d;
        logic [10:0] exp_ev [8] = '{11'h000, 11'h374, 11'h300, 11'h100,
                                    11'h375, 11'h311, 11'h422, 11'h200};
        bus_start();
        bus_byte(8'h74, 1'b0);
        bus_byte(8'h00, 1'b0);
        bus_rstart();
        bus_byte(8'h75, 1'b0);
        bus_byte(8'h11, 1'b0);
        bus_byte(8'h22, 1'b1);
        bus_stop();
        for (int i = 0; i < 8; i++) begin
            pop(d);
            checks++; if (d !== exp_ev[i]) begin errors++; $display("FAIL seq_ev%0d: got %h expected %h", i, d, exp_ev[i]); end
        end
    endtask

    task automatic test_framing_err();
        logic [10:0] d;
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
        bus_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b expected 0", busy); end
        pop(d); checks++; if (d !== 11'h000) begin errors++; $display("FAIL err_ev0: got %h expected 000", d); end
        pop(d); checks++; if (d !== 11'h541) begin errors++; $display("FAIL err_ev1: got %h expected 541", d); end
        repeat (20) @(negedge clk);
        checks++; if (evt_vld !== 1'b0) begin errors++; $display("FAIL err_no_stop: got %b expected 0", evt_vld); end
    endtask

    task automatic test_overflow();
        logic [10:0] d;
        bus_start();
        for (int i = 0; i < 8; i++) bus_byte(8'hA0 + 8'(i), 1'b0);
        bus_stop();
        checks++; if (evt_vld !== 1'b1 || ovr !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovf_flags: got vld=%b ovr=%b busy=%b expected 1 1 0", evt_vld, ovr, busy); end
        pop(d); checks++; if (d !== 11'h000) begin errors++; $display("FAIL ovf_ev0: got %h expected 000", d); end
        for (int i = 0; i < 7; i++) begin
            pop(d);
            checks++; if (d !== (11'h3A0 + 11'(i))) begin errors++; $display("FAIL ovf_ev%0d: got %h expected %h", i + 1, d, 11'h3A0 + 11'(i)); end
        end
        @(negedge clk);
        checks++; if (evt_vld !== 1'b0) begin errors++; $display("FAIL ovf_kept8: got %b expected 0", evt_vld); end
        clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ovr); end

        // Refill to exactly full, then pop in the very cycle the STOP is written.
        bus_start();
        for (int i = 0; i < 7; i++) bus_byte(8'hB0 + 8'(i), 1'b0);
        scl = 1'b0; hold();
        sda = 1'b0; hold();
        scl = 1'b1; hold();
        @(negedge clk) sda = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (evt_dat !== 11'h000) begin errors++; $display("FAIL full_head: got %h expected 000", evt_dat); end
        evt_rd = 1'b1;
        @(negedge clk);
        evt_rd = 1'b0;
        checks++; if (ovr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL coincide_flags: got ovr=%b busy=%b expected 0 0", ovr, busy); end
        for (int i = 0; i < 7; i++) begin
            pop(d);
            checks++; if (d !== (11'h3B0 + 11'(i))) begin errors++; $display("FAIL coincide_ev%0d: got %h expected %h", i, d, 11'h3B0 + 11'(i)); end
        end
        pop(d); checks++; if (d !== 11'h200) begin errors++; $display("FAIL coincide_stop: got %h expected 200", d); end
    endtask

    task automatic test_glitch();
        hold();
        @(negedge clk) sda = 1'b0;
        @(negedge clk) sda = 1'b1;
        repeat (10) @(negedge clk);
        sda = 1'b0;
        repeat (2) @(negedge clk);
        sda = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (evt_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL glitch: got vld=%b busy=%b expected 0 0", evt_vld, busy); end
    endtask

    task automatic test_reset_mid_byte();
        logic [10:0] d;
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
        checks++; if (busy !== 1'b1 || evt_vld !== 1'b1) begin errors++; $display("FAIL pre_rst: got busy=%b vld=%b expected 1 1", busy, evt_vld); end
        rst = 1'b1; sda = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || evt_vld !== 1'b0 || evt_dat !== 11'h000) begin errors++; $display("FAIL mid_rst: got busy=%b vld=%b dat=%h expected 0 0 000", busy, evt_vld, evt_dat); end
        repeat (30) @(negedge clk);
        checks++; if (evt_vld !== 1'b0) begin errors++; $display("FAIL post_rst_quiet: got %b expected 0", evt_vld); end
        bus_start();
        bus_byte(8'h5A, 1'b0);
        bus_stop();
        pop(d); checks++; if (d !== 11'h000) begin errors++; $display("FAIL recov_ev0: got %h expected 000", d); end
        pop(d); checks++; if (d !== 11'h35A) begin errors++; $display("FAIL recov_ev1: got %h expected 35a", d); end
        pop(d); checks++; if (d !== 11'h200) begin errors++; $display("FAIL recov_ev2: got %h expected 200", d); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_nack();
        test_rstart_read();
        test_framing_err();
        test_overflow();
        test_glitch();
        test_reset_mid_byte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
